// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, widths and PC alignment helpers for the fetch stage
package fetch_pkg;

  localparam int          INST_W        = 32;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |(pc & ~PC_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// rtl/fetch_perf_ctr.sv - fetched/stall event counter pair, wrapping at 2^32
module fetch_perf_ctr (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_fetched,
  input  logic        i_stall,
  output logic [31:0] o_fetched,
  output logic [31:0] o_stall
);

  logic [31:0] r_fetched;
  logic [31:0] r_stall;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fetched <= 32'd0;
      r_stall   <= 32'd0;
    end else begin
      if (i_fetched) r_fetched <= r_fetched + 32'd1;
      if (i_stall)   r_stall   <= r_stall + 32'd1;
    end
  end

  assign o_fetched = r_fetched;
  assign o_stall   = r_stall;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch stage owning the PC; FETCH_PERF_EN adds perf_fetched/perf_stall counters
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [31:0]       pc_cur,
  input  logic [31:0]       next_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  output logic              fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  fetch_state_t      r_state;
  logic [31:0]       r_pc;
  logic              r_inst_valid;
  logic [INST_W-1:0] r_inst;
  logic [31:0]       r_inst_pc;
  logic              r_fetch_err;
  logic              w_accept;

  // a flush in the same cycle overrides the decode handshake
  assign w_accept = (r_state == HOLD) && inst_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= REQ;
      r_pc         <= RESET_PC;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= 32'd0;
      r_fetch_err  <= 1'b0;
    end else if (flush) begin
      r_pc         <= align_pc(flush_pc);
      r_inst_valid <= 1'b0;
      if (pc_misaligned(flush_pc)) r_fetch_err <= 1'b1;
      // an outstanding read must be drained so its data is never taken for the new PC
      case (r_state)
        REQ:     r_state <= imem_gnt ? DRAIN : REQ;
        WAIT:    r_state <= imem_rvalid ? REQ : DRAIN;
        HOLD:    r_state <= REQ;
        default: r_state <= imem_rvalid ? REQ : DRAIN;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (imem_gnt) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_inst       <= imem_rdata;
            r_inst_pc    <= r_pc;
            r_inst_valid <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          if (w_accept) begin
            r_pc         <= align_pc(next_pc);
            r_inst_valid <= 1'b0;
            r_state      <= REQ;
            if (pc_misaligned(next_pc)) r_fetch_err <= 1'b1;
          end
        end
        default: begin
          if (imem_rvalid) r_state <= REQ;
        end
      endcase
    end
  end

  assign imem_req   = rst_n && (r_state == REQ);
  assign imem_addr  = r_pc;
  assign pc_cur     = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fetch_err  = r_fetch_err;

`ifdef FETCH_PERF_EN
  logic w_stall;

  assign w_stall = (r_state != HOLD);

  fetch_perf_ctr u_perf (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_fetched (w_accept),
    .i_stall   (w_stall),
    .o_fetched (perf_fetched),
    .o_stall   (perf_stall)
  );
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit with a latency-programmable memory model
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_err;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic        gnt_en;
  int          rv_lat;
  logic        npc_ovr;
  logic [31:0] npc_val;
  int          n_tests;
  int          n_fail;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_cur      (pc_cur),
    .next_pc     (next_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_err   (fetch_err)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pc_branch stand-in: sequential next PC unless overridden
  assign next_pc  = npc_ovr ? npc_val : pc_cur + 32'd4;
  assign imem_gnt = imem_req & gnt_en;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return 32'h2001_0005 + (a << 8);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] a);
    exp_t e;
    e.inst = w;
    e.pc   = a;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!inst_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic wait_fire(input string nm, input logic [31:0] addr, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(imem_req && imem_gnt) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_fired"}, {31'd0, imem_req && imem_gnt}, 32'd1);
    chk({nm, "_addr"}, imem_addr, addr);
  endtask

  task automatic wait_empty(input string nm, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, exp_q.size(), 32'd0);
  endtask

  // memory: grants per gnt_en, returns read data rv_lat cycles after the grant cycle
  initial begin : mem_model
    logic        m_fire;
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_faddr;
    logic [31:0] m_addr;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    m_pend      = 1'b0;
    m_cnt       = 0;
    m_addr      = 32'd0;
    forever begin
      @(negedge clk);
      m_fire  = imem_req && imem_gnt;
      m_faddr = imem_addr;
      @(posedge clk);
      #1;
      if (m_fire) begin
        m_pend = 1'b1;
        m_cnt  = rv_lat;
        m_addr = m_faddr;
      end
      imem_rvalid = 1'b0;
      if (m_pend) begin
        if (m_cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_of(m_addr);
          m_pend      = 1'b0;
        end else begin
          m_cnt--;
        end
      end
    end
  end

  // monitor: every accepted instruction must match the head of the scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !flush && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_inst: got inst %h pc %h with empty scoreboard", inst, inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst", inst, e.inst);
          chk("sb_inst_pc", inst_pc, e.pc);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int fires;
    int vcnt;
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    gnt_en     = 1'b1;
    rv_lat     = 1;
    inst_ready = 1'b1;
    flush      = 1'b0;
    flush_pc   = 32'd0;
    npc_ovr    = 1'b0;
    npc_val    = 32'd0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc_cur", pc_cur, 32'h0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

    // zero-wait stream: grants at 0x0/0x4/0x8, valid every third cycle
    push(32'h2001_0005, 32'h0);
    push(32'h2001_0405, 32'h4);
    push(32'h2001_0805, 32'h8);
    step();
    rst_n = 1'b1;
    fires = 0;
    vcnt  = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        chk("s1_addr", imem_addr, 32'(fires * 4));
        chk("s1_fire_cycle", k, 32'(fires * 3));
        fires++;
      end
      if (inst_valid) begin
        chk("s1_valid_cycle", k, 32'(vcnt * 3 + 2));
        vcnt++;
      end
    end
    chk("s1_fires", fires, 32'd3);
    chk("s1_valids", vcnt, 32'd3);

    // backpressure: 5 cycles of inst_ready=0 in HOLD
    step();
    inst_ready = 1'b0;
    push(32'h2001_0C05, 32'hC);
    wait_valid("s2_valid", 10);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("s2_inst", inst, 32'h2001_0C05);
      chk("s2_inst_pc", inst_pc, 32'hC);
      chk("s2_no_req", {31'd0, imem_req}, 32'd0);
      chk("s2_pc_cur", pc_cur, 32'hC);
      chk("s2_valid_hold", {31'd0, inst_valid}, 32'd1);
    end
    step();
    inst_ready = 1'b1;
    rv_lat     = 3;

    // flush to 0x100 during WAIT, stale data arrives two cycles later
    wait_fire("s3_first", 32'h10, 10);
    step();
    flush    = 1'b1;
    flush_pc = 32'h100;
    step();
    flush  = 1'b0;
    rv_lat = 1;
    push(32'h2002_0005, 32'h100);
    @(negedge clk);
    chk("s3_drain_req", {31'd0, imem_req}, 32'd0);
    chk("s3_pc_cur", pc_cur, 32'h100);
    chk("s3_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("s3_drain_req2", {31'd0, imem_req}, 32'd0);
    wait_fire("s3_refetch", 32'h100, 10);
    wait_empty("s3_sb_empty", 10);

    // flush and handshake in the same HOLD cycle
    step();
    inst_ready = 1'b0;
    wait_valid("s4_valid", 10);
    chk("s4_inst_pc", inst_pc, 32'h104);
    step();
    flush      = 1'b1;
    flush_pc   = 32'h40;
    inst_ready = 1'b1;
    npc_ovr    = 1'b1;
    npc_val    = 32'h8;
    step();
    flush   = 1'b0;
    npc_val = 32'h13;
    push(32'h2001_4005, 32'h40);
    @(negedge clk);
    chk("s4_pc_cur", pc_cur, 32'h40);
    chk("s4_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("s4_valid", {31'd0, inst_valid}, 32'd0);
    wait_empty("s4_sb_empty", 10);

    // misaligned next_pc 0x13 on handshake, err stays set over 10 fetches
    step();
    npc_ovr = 1'b0;
    @(negedge clk);
    chk("s5_pc_cur", pc_cur, 32'h10);
    chk("s5_fetch_err", {31'd0, fetch_err}, 32'd1);
    for (int i = 0; i < 10; i++) push(mem_of(32'h10 + 32'(i * 4)), 32'h10 + 32'(i * 4));
    wait_empty("s5_sb_empty", 60);
    step();
    rv_lat = 3;
    chk("s5_pc_after", pc_cur, 32'h38);
    chk("s5_err_sticky", {31'd0, fetch_err}, 32'd1);

    // reset for one cycle in WAIT; stale rvalid then lands in REQ
    wait_fire("s6_fire", 32'h38, 10);
    step();
    rst_n  = 1'b0;
    gnt_en = 1'b0;
    @(negedge clk);
    chk("s6_rst_req", {31'd0, imem_req}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_pc_cur", pc_cur, 32'h0);
    chk("s6_valid", {31'd0, inst_valid}, 32'd0);
    chk("s6_fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("s6_req", {31'd0, imem_req}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s6_stale_ignored", {31'd0, inst_valid}, 32'd0);
      chk("s6_addr", imem_addr, 32'h0);
    end
    step();
    gnt_en = 1'b1;
    rv_lat = 1;
    push(32'h2001_0005, 32'h0);
    wait_empty("s6_sb_empty", 20);
    step();
    inst_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
